// File: rtl/exc_seq_ctrl.sv
// Exception/interrupt sequencer between pipeline control and CP0.
// Optional statistics counters are built when EXC_STAT_EN is defined.
module exc_seq_ctrl #(
  parameter logic [31:0] HANDLER_VEC = 32'h0000_4180,
  parameter int          DRAIN_MAX   = 4,
  parameter int          CNT_W       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        sys_exc,
  input  logic [4:0]  exc_code,
  input  logic        eret,
  input  logic        inst_done,
  input  logic [31:0] pc_commit,
  input  logic [31:0] epc_in,
  output logic        stall,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        exlset,
  output logic        exlclr,
  output logic        cp0_we,
  output logic [4:0]  cp0_addr,
  output logic [31:0] epc_val,
  output logic [4:0]  cause_code,
  output logic        busy,
  output logic        exc_err
`ifdef EXC_STAT_EN
  ,
  output logic [15:0] exc_count,
  output logic [15:0] int_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_ENTER, S_HANDLER, S_RETURN} state_t;

  state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0] epc_reg, epc_next;
  logic [4:0]  code_reg, code_next;
  logic        err_reg, err_next;
  logic [31:0] next_pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      epc_reg     <= '0;
      code_reg    <= '0;
      err_reg     <= 1'b0;
      next_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      epc_reg   <= epc_next;
      code_reg  <= code_next;
      err_reg   <= err_next;
      if (inst_done)
        next_pc_reg <= pc_commit + 32'd4;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    epc_next   = epc_reg;
    code_next  = code_reg;
    err_next   = err_reg;
    case (state_reg)
      S_IDLE: begin
        // A committing synchronous exception beats a pending interrupt;
        // the interrupt is level-sensitive and is picked up after RETURN.
        if (sys_exc && inst_done) begin
          epc_next   = pc_commit;
          code_next  = exc_code;
          state_next = S_ENTER;
        end else if (int_req) begin
          cnt_next   = '0;
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (inst_done && sys_exc) begin
          epc_next   = pc_commit;
          code_next  = exc_code;
          state_next = S_ENTER;
        end else if (inst_done) begin
          epc_next   = pc_commit + 32'd4;
          code_next  = 5'd0;
          state_next = S_ENTER;
        end else if (cnt_reg == CNT_W'(DRAIN_MAX - 1)) begin
          epc_next   = next_pc_reg;
          code_next  = 5'd0;
          state_next = S_ENTER;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_ENTER: state_next = S_HANDLER;
      S_HANDLER: begin
        if (eret && inst_done)
          state_next = S_RETURN;
        else if (sys_exc && inst_done)
          err_next = 1'b1;
      end
      S_RETURN: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs decode the registered state, so every strobe lasts one cycle.
  always_comb begin
    stall       = (state_reg == S_DRAIN);
    exlset      = (state_reg == S_ENTER);
    cp0_we      = (state_reg == S_ENTER);
    cp0_addr    = (state_reg == S_ENTER) ? 5'd14 : 5'd0;
    exlclr      = (state_reg == S_RETURN);
    flush       = (state_reg == S_ENTER) || (state_reg == S_RETURN);
    pc_redirect = (state_reg == S_ENTER) || (state_reg == S_RETURN);
    pc_target   = 32'd0;
    if (state_reg == S_ENTER)
      pc_target = HANDLER_VEC;
    else if (state_reg == S_RETURN)
      pc_target = epc_in;
    epc_val    = epc_reg;
    cause_code = code_reg;
    busy       = (state_reg != S_IDLE);
    exc_err    = err_reg;
  end

`ifdef EXC_STAT_EN
  logic entering;
  assign entering = (state_next == S_ENTER) && (state_reg != S_ENTER);

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_count <= '0;
      int_count <= '0;
    end else if (entering) begin
      if (code_next == 5'd0) begin
        if (int_count != 16'hFFFF) int_count <= int_count + 16'd1;
      end else begin
        if (exc_count != 16'hFFFF) exc_count <= exc_count + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// Directed self-checking bench for exc_seq_ctrl (EXC_STAT_EN adds counter checks).
module tb_exc_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, int_req, sys_exc, eret, inst_done;
  logic [4:0]  exc_code;
  logic [31:0] pc_commit, epc_in;
  logic        stall, flush, pc_redirect, exlset, exlclr, cp0_we, busy, exc_err;
  logic [31:0] pc_target, epc_val;
  logic [4:0]  cp0_addr, cause_code;
`ifdef EXC_STAT_EN
  logic [15:0] exc_count, int_count;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  exc_seq_ctrl dut (
    .clk(clk), .rst(rst), .int_req(int_req), .sys_exc(sys_exc), .exc_code(exc_code),
    .eret(eret), .inst_done(inst_done), .pc_commit(pc_commit), .epc_in(epc_in),
    .stall(stall), .flush(flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .exlset(exlset), .exlclr(exlclr), .cp0_we(cp0_we), .cp0_addr(cp0_addr),
    .epc_val(epc_val), .cause_code(cause_code), .busy(busy), .exc_err(exc_err)
`ifdef EXC_STAT_EN
    , .exc_count(exc_count), .int_count(int_count)
`endif
  );

  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    int_req = 0; sys_exc = 0; eret = 0; inst_done = 0; exc_code = 0;
  endtask

  task automatic do_eret(input logic [31:0] e);
    eret = 1; inst_done = 1; epc_in = e; pc_commit = 32'h0000_4200;
    step();
    eret = 0; inst_done = 0;
    checks++; if (exlclr !== 1'b1) $display("FAIL eret_exlclr got=%0h exp=1", exlclr); else passed++;
    checks++; if (pc_target !== e) $display("FAIL eret_target got=%h exp=%h", pc_target, e); else passed++;
    checks++; if ({exlset, flush, pc_redirect} !== 3'b011) $display("FAIL eret_pulses got=%b exp=011", {exlset, flush, pc_redirect}); else passed++;
    step();
    checks++; if (busy !== 1'b0) $display("FAIL eret_idle_busy got=%0h exp=0", busy); else passed++;
    checks++; if (exlclr !== 1'b0) $display("FAIL eret_exlclr_once got=%0h exp=0", exlclr); else passed++;
  endtask

  task automatic test_reset();
    idle_inputs(); pc_commit = 0; epc_in = 0; rst = 1;
    step(); step();
    rst = 0;
    checks++; if ({busy, stall, exlset, exlclr, cp0_we, flush, pc_redirect, exc_err} !== 8'h00)
      $display("FAIL reset_flags got=%b exp=00000000", {busy, stall, exlset, exlclr, cp0_we, flush, pc_redirect, exc_err}); else passed++;
    checks++; if ({pc_target, epc_val, cause_code} !== 69'd0)
      $display("FAIL reset_values got=%h/%h/%h exp=0", pc_target, epc_val, cause_code); else passed++;
    int_req = 1;
    step();
    checks++; if ({busy, stall} !== 2'b11) $display("FAIL drain_stall got=%b exp=11", {busy, stall}); else passed++;
    rst = 1;
    step();
    rst = 0; int_req = 0;
    checks++; if ({busy, stall, exlset, flush, pc_redirect, cp0_we, exc_err} !== 7'h00)
      $display("FAIL reset_mid_drain got=%b exp=0000000", {busy, stall, exlset, flush, pc_redirect, cp0_we, exc_err}); else passed++;
  endtask

  task automatic test_syscall();
    sys_exc = 1; exc_code = 5'd8; inst_done = 1; pc_commit = 32'h0000_3010;
    step();
    idle_inputs();
    checks++; if ({exlset, cp0_we, flush, pc_redirect, stall} !== 5'b11110)
      $display("FAIL sys_pulses got=%b exp=11110", {exlset, cp0_we, flush, pc_redirect, stall}); else passed++;
    checks++; if (cp0_addr !== 5'd14) $display("FAIL sys_cp0_addr got=%0d exp=14", cp0_addr); else passed++;
    checks++; if (epc_val !== 32'h0000_3010) $display("FAIL sys_epc got=%h exp=00003010", epc_val); else passed++;
    checks++; if (cause_code !== 5'd8) $display("FAIL sys_cause got=%0d exp=8", cause_code); else passed++;
    checks++; if (pc_target !== 32'h0000_4180) $display("FAIL sys_target got=%h exp=00004180", pc_target); else passed++;
    step();
    checks++; if ({busy, exlset, cp0_we, flush, pc_redirect} !== 5'b10000)
      $display("FAIL handler_quiet got=%b exp=10000", {busy, exlset, cp0_we, flush, pc_redirect}); else passed++;
    do_eret(32'h0000_3014);
  endtask

  task automatic test_int_commit();
    int_req = 1;
    step();
    checks++; if ({stall, pc_redirect} !== 2'b10) $display("FAIL int_drain1 got=%b exp=10", {stall, pc_redirect}); else passed++;
    step();
    checks++; if ({stall, pc_redirect} !== 2'b10) $display("FAIL int_drain2 got=%b exp=10", {stall, pc_redirect}); else passed++;
    inst_done = 1; pc_commit = 32'h0000_3020;
    step();
    idle_inputs();
    checks++; if ({exlset, stall} !== 2'b10) $display("FAIL int_enter got=%b exp=10", {exlset, stall}); else passed++;
    checks++; if (epc_val !== 32'h0000_3024) $display("FAIL int_epc got=%h exp=00003024", epc_val); else passed++;
    checks++; if (cause_code !== 5'd0) $display("FAIL int_cause got=%0d exp=0", cause_code); else passed++;
    step();
    do_eret(32'h0000_3024);
  endtask

  task automatic test_drain_timeout();
    inst_done = 1; pc_commit = 32'h0000_3000;
    step();
    inst_done = 0;
    checks++; if (busy !== 1'b0) $display("FAIL commit_idle_busy got=%0h exp=0", busy); else passed++;
    int_req = 1;
    step();
    int_req = 0;  // dropping the request must not abort entry
    checks++; if (stall !== 1'b1) $display("FAIL timeout_drain1 got=%0h exp=1", stall); else passed++;
    for (int k = 2; k <= 4; k++) begin
      step();
      checks++; if ({stall, exlset} !== 2'b10) $display("FAIL timeout_drain%0d got=%b exp=10", k, {stall, exlset}); else passed++;
    end
    step();
    checks++; if ({exlset, stall} !== 2'b10) $display("FAIL timeout_enter got=%b exp=10", {exlset, stall}); else passed++;
    checks++; if (epc_val !== 32'h0000_3004) $display("FAIL timeout_epc got=%h exp=00003004", epc_val); else passed++;
    step();
    do_eret(32'h0000_3004);
  endtask

  task automatic test_back_to_back();
    sys_exc = 1; exc_code = 5'd5; inst_done = 1; pc_commit = 32'h0000_3040; int_req = 1;
    step();
    sys_exc = 0; inst_done = 0; exc_code = 0;
    checks++; if ({exlset, cause_code} !== {1'b1, 5'd5}) $display("FAIL same_cycle_enter got=%b/%0d exp=1/5", exlset, cause_code); else passed++;
    checks++; if (epc_val !== 32'h0000_3040) $display("FAIL same_cycle_epc got=%h exp=00003040", epc_val); else passed++;
    step();
    checks++; if ({busy, stall} !== 2'b10) $display("FAIL handler_ignores_int got=%b exp=10", {busy, stall}); else passed++;
    do_eret(32'h0000_3044);
    checks++; if (stall !== 1'b0) $display("FAIL post_return_idle got=%0h exp=0", stall); else passed++;
    step();
    checks++; if (stall !== 1'b1) $display("FAIL pending_int_drain got=%0h exp=1", stall); else passed++;
    inst_done = 1; pc_commit = 32'h0000_3050;
    step();
    idle_inputs();
    checks++; if ({exlset, cause_code} !== {1'b1, 5'd0}) $display("FAIL pending_int_enter got=%b/%0d exp=1/0", exlset, cause_code); else passed++;
    checks++; if (epc_val !== 32'h0000_3054) $display("FAIL pending_int_epc got=%h exp=00003054", epc_val); else passed++;
    step();
    do_eret(32'h0000_3054);
  endtask

  task automatic test_double_fault();
    sys_exc = 1; exc_code = 5'd8; inst_done = 1; pc_commit = 32'h0000_3060;
    step();
    idle_inputs();
    step();
    checks++; if (exc_err !== 1'b0) $display("FAIL err_before got=%0h exp=0", exc_err); else passed++;
    sys_exc = 1; exc_code = 5'd10; inst_done = 1; pc_commit = 32'h0000_4190;
    step();
    idle_inputs();
    checks++; if (exc_err !== 1'b1) $display("FAIL err_set got=%0h exp=1", exc_err); else passed++;
    checks++; if ({busy, exlset, cp0_we, flush, pc_redirect, stall} !== 6'b100000)
      $display("FAIL err_no_pulses got=%b exp=100000", {busy, exlset, cp0_we, flush, pc_redirect, stall}); else passed++;
    checks++; if (cause_code !== 5'd8) $display("FAIL err_cause_kept got=%0d exp=8", cause_code); else passed++;
    step();
    do_eret(32'h0000_3064);
    checks++; if (exc_err !== 1'b1) $display("FAIL err_sticky got=%0h exp=1", exc_err); else passed++;
    rst = 1;
    step();
    rst = 0;
    checks++; if (exc_err !== 1'b0) $display("FAIL err_cleared got=%0h exp=0", exc_err); else passed++;
  endtask

  task automatic test_stats();
`ifdef EXC_STAT_EN
    checks++; if ({exc_count, int_count} !== 32'd0) $display("FAIL stat_reset got=%0d/%0d exp=0/0", exc_count, int_count); else passed++;
    sys_exc = 1; exc_code = 5'd8; inst_done = 1; pc_commit = 32'h0000_3070;
    step();
    idle_inputs();
    step();
    do_eret(32'h0000_3070);
    int_req = 1;
    step();
    inst_done = 1; pc_commit = 32'h0000_3080;
    step();
    idle_inputs();
    step();
    do_eret(32'h0000_3084);
    checks++; if (exc_count !== 16'd1) $display("FAIL stat_exc got=%0d exp=1", exc_count); else passed++;
    checks++; if (int_count !== 16'd1) $display("FAIL stat_int got=%0d exp=1", int_count); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_int_commit();
    test_drain_timeout();
    test_back_to_back();
    test_double_fault();
    test_stats();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/exc_seq_ctrl.md
Name: exc_seq_ctrl

Overview:
- Exception/interrupt sequencer between the pipeline control and the CP0 register block.
- Decides when an exception is taken and drives CP0 side-band controls: exlset, exlclr, the EPC write, the cause code.
- Drives stall/flush and the PC redirect for handler entry and for ERET return.
- Holds at most one exception in flight. Nesting is prevented because CP0 masks interrupts while EXL is set.

Parameters:
- HANDLER_VEC, 32'h0000_4180, handler entry address driven on pc_target at entry.
- DRAIN_MAX, 4, maximum cycles waited for an instruction commit before an interrupt is forced.
- CNT_W, 3, width of the drain counter; must satisfy 2^CNT_W > DRAIN_MAX.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- int_req  in  1  level interrupt request from CP0 (int_req_sel)
- sys_exc  in  1  synchronous exception (syscall/illegal) from decode; valid with inst_done
- exc_code  in  5  cause code accompanying sys_exc
- eret  in  1  ERET decoded; valid with inst_done
- inst_done  in  1  one-cycle pulse: the instruction at pc_commit commits this cycle
- pc_commit  in  32  PC of the committing instruction
- epc_in  in  32  CP0 epc_out
- stall  out  1  freeze fetch/decode
- flush  out  1  kill all in-flight instructions
- pc_redirect  out  1  load pc_target into the PC this cycle
- pc_target  out  32  redirect address
- exlset  out  1  CP0 EXL set strobe
- exlclr  out  1  CP0 EXL clear strobe
- cp0_we  out  1  CP0 write enable (EPC capture)
- cp0_addr  out  5  CP0 register select while cp0_we is high (5'd14)
- epc_val  out  32  value for CP0 pc_in
- cause_code  out  5  latched code (interrupt = 5'd0)
- busy  out  1  high in any state other than IDLE
- exc_err  out  1  sticky: sys_exc received while in HANDLER

Behaviour:
- Reset: all state is updated on the clk edge while rst is high; reset takes effect mid-operation too.
  - State goes to IDLE and the drain counter to 0.
  - Every output is 0, including pc_target, epc_val, cause_code and exc_err.
- next_pc register: updated to pc_commit+4 (mod 2^32) on every inst_done.
- State IDLE:
  - sys_exc & inst_done: latch epc = pc_commit and code = exc_code; go to ENTER. This has priority over int_req in the same cycle. The interrupt stays pending because it is level-sensitive.
  - else int_req: stall=1, counter=0, go to DRAIN.
  - eret in IDLE: ignored.
- State DRAIN (stall held at 1):
  - inst_done without sys_exc: epc = pc_commit+4, code = 0, go to ENTER.
  - inst_done with sys_exc: sys_exc wins; same action as in IDLE.
  - counter == DRAIN_MAX-1 with no commit: epc = next_pc, code = 0, go to ENTER.
  - otherwise the counter increments.
  - int_req dropping while in DRAIN does not abort entry.
- State ENTER, exactly one cycle:
  - Pulsed high: exlset, cp0_we (cp0_addr=14), flush, pc_redirect.
  - pc_target = HANDLER_VEC; epc_val = latched epc; cause_code = latched code.
  - stall=0. Next state HANDLER.
- State HANDLER:
  - eret & inst_done: go to RETURN.
  - sys_exc & inst_done: set exc_err (sticky until rst), stay in HANDLER.
  - int_req is ignored.
- State RETURN, exactly one cycle:
  - Pulsed high: exlclr, flush, pc_redirect; pc_target = epc_in.
  - Next state IDLE.
  - An interrupt pending at RETURN is evaluated in IDLE on the following cycle.
- Latency:
  - Synchronous exception commit to handler redirect: 1 cycle.
  - Interrupt to redirect: 2 to DRAIN_MAX+1 cycles.
  - ERET commit to return redirect: 1 cycle.
- Pulse outputs are registered and never high for two consecutive cycles.
- exlset and exlclr are never high in the same cycle.

Optional Feature:
- Macro: EXC_STAT_EN.
- Defined:
  - Adds outputs exc_count (16) and int_count (16).
  - Each increments on entry to ENTER: int_count when code==0, exc_count otherwise.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-DRAIN: int_req=1, then rst after 1 cycle -> next cycle busy=0, stall=0, all pulses 0, exc_err=0.
- Syscall: sys_exc=1, exc_code=8, inst_done, pc_commit=0x0000_3010 -> next cycle exlset=cp0_we=flush=pc_redirect=1, epc_val=0x3010, cause_code=8, pc_target=0x4180.
- Interrupt with commit: int_req=1, inst_done on the 2nd DRAIN cycle with pc_commit=0x3020 -> stall=1 during DRAIN, then ENTER with epc_val=0x3024, cause_code=0.
- Drain timeout: int_req=1, no inst_done; last earlier commit pc=0x3000 -> ENTER after exactly DRAIN_MAX (4) DRAIN cycles, epc_val=0x3004.
- ERET: in HANDLER, eret & inst_done with epc_in=0x3024 -> next cycle exlclr=1, pc_target=0x3024, then busy=0. Same-cycle sys_exc+int_req in IDLE -> ENTER with sys_exc code; interrupt taken after RETURN.
- Double fault: sys_exc & inst_done in HANDLER -> exc_err=1, state unchanged, no pulses. With EXC_STAT_EN: one syscall plus one interrupt -> exc_count=1, int_count=1.
